jk_stim_gen: RTL and testbench

//  Upstream driver for the JK flip-flop stage. Debounces two board buttons and

---
 rtl/jk_stim_gen_pkg.sv | 20 ++
 rtl/jk_stim_gen_btn_debounce.sv | 47 ++++
 rtl/jk_stim_gen.sv | 129 ++++++++++++
 tb/tb_jk_stim_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_stim_gen_pkg.sv
// Shared types and helpers for the JK stimulus generator.
// Mode codes and counter-width helper used by jk_stim_gen and btn_debounce.
package jk_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SET  = 2'b01,
        MODE_CLR  = 2'b10,
        MODE_TOG  = 2'b11
    } mode_e;

    // Never returns less than 1 so counters always have a real bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/jk_stim_gen_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a
// registered one-cycle rising-edge flag.
module btn_debounce
    import jk_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_in,
    output logic stable,
    output logic rise
);

    localparam int unsigned DB_W = clog2(DB_CYCLES);

    logic            sync1;
    logic            sync2;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw_in;
            sync2    <= sync1;
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            // Any agreeing sample restarts the stability window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_stim_gen.sv
// J/K stimulus driver: debounced buttons, 4-mode FSM, STEP strobe and counter.
// Optional AUTO_STEP_EN adds a prescaler that requests steps while SW_AUTO=1.
module jk_stim_gen
    import jk_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned AUTO_DIV  = 50000000,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_STEP,
    input  logic             BTN_MODE,
    input  logic             SW_AUTO,
    output logic             J,
    output logic             K,
    output logic             STEP,
    output logic [1:0]       MODE,
    output logic [CNT_W-1:0] STEP_CNT
);

    logic  step_rise;
    logic  mode_rise;
    logic  unused_step_lvl;
    logic  unused_mode_lvl;
    logic  auto_tick;
    logic  step_req;

    mode_e mode_q;
    mode_e mode_d;
    logic  pend_q;
    logic  pend_d;
    logic  step_d;
    logic  j_d;
    logic  k_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .CLK    (CLK),
        .RST    (RST),
        .raw_in (BTN_STEP),
        .stable (unused_step_lvl),
        .rise   (step_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .CLK    (CLK),
        .RST    (RST),
        .raw_in (BTN_MODE),
        .stable (unused_mode_lvl),
        .rise   (mode_rise)
    );

`ifdef AUTO_STEP_EN
    localparam int unsigned AD_W = clog2(AUTO_DIV);

    logic [AD_W-1:0] pre_q;

    assign auto_tick = SW_AUTO && (pre_q == AD_W'(AUTO_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || !SW_AUTO) begin
            pre_q <= '0;
        end else if (auto_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end
`else
    logic unused_sw_auto;

    assign unused_sw_auto = SW_AUTO;
    assign auto_tick      = 1'b0;
`endif

    assign step_req = step_rise | auto_tick;

    // A mode change holds back any step by one cycle so the
    // strobe never coincides with a J/K update.
    always_comb begin
        mode_d = mode_q;
        pend_d = 1'b0;
        step_d = 1'b0;
        j_d    = 1'b0;
        k_d    = 1'b0;
        if (mode_rise) begin
            unique case (mode_q)
                MODE_HOLD: mode_d = MODE_SET;
                MODE_SET:  mode_d = MODE_CLR;
                MODE_CLR:  mode_d = MODE_TOG;
                MODE_TOG:  mode_d = MODE_HOLD;
                default:   mode_d = MODE_HOLD;
            endcase
            pend_d = pend_q | step_req;
        end else begin
            step_d = step_req | pend_q;
        end
        unique case (mode_d)
            MODE_HOLD: begin j_d = 1'b0; k_d = 1'b0; end
            MODE_SET:  begin j_d = 1'b1; k_d = 1'b0; end
            MODE_CLR:  begin j_d = 1'b0; k_d = 1'b1; end
            MODE_TOG:  begin j_d = 1'b1; k_d = 1'b1; end
            default:   begin j_d = 1'b0; k_d = 1'b0; end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q   <= MODE_HOLD;
            pend_q   <= 1'b0;
            J        <= 1'b0;
            K        <= 1'b0;
            STEP     <= 1'b0;
            STEP_CNT <= '0;
        end else begin
            mode_q <= mode_d;
            pend_q <= pend_d;
            J      <= j_d;
            K      <= k_d;
            STEP   <= step_d;
            if (step_d) begin
                STEP_CNT <= STEP_CNT + 1'b1;
            end
        end
    end

    assign MODE = mode_q;

endmodule

// File: tb/tb_jk_stim_gen.sv
// Bench for jk_stim_gen: behavioural model compared every cycle plus
// directed button scenarios with literal expectations.
module tb_jk_stim_gen;

    localparam int DB = 4;
    localparam int AD = 8;
    localparam int CW = 8;
`ifdef AUTO_STEP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          BTN_STEP;
    logic          BTN_MODE;
    logic          SW_AUTO;
    logic          J;
    logic          K;
    logic          STEP;
    logic [1:0]    MODE;
    logic [CW-1:0] STEP_CNT;

    always #5 CLK = ~CLK;

    jk_stim_gen #(
        .DB_CYCLES (DB),
        .AUTO_DIV  (AD),
        .CNT_W     (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_STEP (BTN_STEP),
        .BTN_MODE (BTN_MODE),
        .SW_AUTO  (SW_AUTO),
        .J        (J),
        .K        (K),
        .STEP     (STEP),
        .MODE     (MODE),
        .STEP_CNT (STEP_CNT)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    bit armed  = 1'b0;

    // Model: raw sample history per button, accepted levels,
    // two-edge delay from acceptance to action, mode and step state.
    bit          hs[DB+2];
    bit          hm[DB+2];
    bit          sv_s;
    bit          sv_m;
    bit [1:0]    rq_s;
    bit [1:0]    rq_m;
    int          run;
    bit          pend;
    bit [1:0]    m_mode;
    bit          m_step;
    bit [CW-1:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic bit [1:0] jk_of(input bit [1:0] m);
        case (m)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic model_edge();
        bit fs, fm, act_s, act_m, tick, req;
        for (int i = DB + 1; i > 0; i--) begin
            hs[i] = hs[i-1];
            hm[i] = hm[i-1];
        end
        hs[0] = BTN_STEP;
        hm[0] = BTN_MODE;
        if (RST) begin
            for (int i = 0; i < DB + 2; i++) begin
                hs[i] = 1'b0;
                hm[i] = 1'b0;
            end
            sv_s = 0; sv_m = 0; rq_s = 0; rq_m = 0; run = 0;
            pend = 0; m_mode = 0; m_step = 0; m_cnt = 0;
            armed = 1'b1;
            return;
        end
        // A level is accepted once DB synchronised samples all disagree
        // with the current level; synchroniser delay is two samples.
        fs = 1'b1;
        fm = 1'b1;
        for (int i = 2; i <= DB + 1; i++) begin
            if (hs[i] == sv_s) fs = 1'b0;
            if (hm[i] == sv_m) fm = 1'b0;
        end
        act_s = rq_s[1];
        act_m = rq_m[1];
        rq_s  = {rq_s[0], fs & ~sv_s};
        rq_m  = {rq_m[0], fm & ~sv_m};
        if (fs) sv_s = ~sv_s;
        if (fm) sv_m = ~sv_m;
        tick = 1'b0;
        if (AUTO && SW_AUTO === 1'b1) begin
            run++;
            tick = (run % AD) == 0;
        end else begin
            run = 0;
        end
        req = act_s | tick;
        if (act_m) begin
            m_mode++;
            pend   = pend | req;
            m_step = 1'b0;
        end else begin
            m_step = req | pend;
            pend   = 1'b0;
        end
        if (m_step) m_cnt++;
    endtask

    task automatic cyc_t(input int n = 1);
        bit [1:0] ejk;
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            #1;
            cyc++;
            if (STEP === 1'b1) pulses++;
            if (armed) begin
                ejk = jk_of(m_mode);
                check("j",    32'(J),        32'(ejk[1]));
                check("k",    32'(K),        32'(ejk[0]));
                check("mode", 32'(MODE),     32'(m_mode));
                check("step", 32'(STEP),     32'(m_step));
                check("cnt",  32'(STEP_CNT), 32'(m_cnt));
            end
        end
    endtask

    task automatic press_mode();
        BTN_MODE = 1'b1;
        cyc_t(10);
        BTN_MODE = 1'b0;
        cyc_t(10);
    endtask

    initial begin
        int base;
        int t0;
        int t;
        bit seen;
        logic [1:0] seq[4];
        int ptimes[5];
        int np;

        RST = 1'b1; BTN_STEP = 1'b0; BTN_MODE = 1'b0; SW_AUTO = 1'b0;
        cyc_t(2);
        RST = 1'b0;
        cyc_t(1);
        check("t1_j",    32'(J),        32'd0);
        check("t1_k",    32'(K),        32'd0);
        check("t1_mode", 32'(MODE),     32'd0);
        check("t1_step", 32'(STEP),     32'd0);
        check("t1_cnt",  32'(STEP_CNT), 32'd0);

        press_mode();
        check("t2_mode", 32'(MODE), 32'd1);
        check("t2_j",    32'(J),    32'd1);
        check("t2_k",    32'(K),    32'd0);
        seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            press_mode();
            check("t2_wrap", 32'(MODE), 32'(seq[i]));
        end

        base = pulses;
        BTN_STEP = 1'b1; cyc_t(1);
        BTN_STEP = 1'b0; cyc_t(1);
        BTN_STEP = 1'b1; cyc_t(1);
        BTN_STEP = 1'b0; cyc_t(1);
        BTN_STEP = 1'b1;
        t0 = cyc;
        t = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc_t(1);
            if (STEP === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check("t3_seen",    32'(seen),   32'd1);
        check("t3_latency", 32'(t - t0), 32'd8);
        cyc_t(10);
        BTN_STEP = 1'b0;
        cyc_t(10);
        check("t3_pulses", 32'(pulses - base), 32'd1);
        check("t3_cnt",    32'(STEP_CNT),      32'd1);

        press_mode(); press_mode(); press_mode();
        check("t4_pre_mode", 32'(MODE), 32'd0);
        BTN_MODE = 1'b1;
        BTN_STEP = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc_t(1);
            if (MODE === 2'd1) seen = 1'b1;
        end
        check("t4_mode_seen", 32'(seen), 32'd1);
        check("t4_step_n",    32'(STEP), 32'd0);
        cyc_t(1);
        check("t4_step_n1", 32'(STEP),     32'd1);
        check("t4_j",       32'(J),        32'd1);
        check("t4_k",       32'(K),        32'd0);
        check("t4_cnt",     32'(STEP_CNT), 32'd2);
        cyc_t(5);
        BTN_MODE = 1'b0;
        BTN_STEP = 1'b0;
        cyc_t(10);

        RST = 1'b1;
        cyc_t(2);
        RST = 1'b0;
        base = pulses;
        for (int i = 0; i < 256; i++) begin
            BTN_STEP = 1'b1;
            cyc_t(8);
            BTN_STEP = 1'b0;
            cyc_t(8);
        end
        check("t5_pulses", 32'(pulses - base), 32'd256);
        check("t5_wrap",   32'(STEP_CNT),      32'd0);
        BTN_STEP = 1'b1;
        cyc_t(4);
        RST = 1'b1;
        BTN_STEP = 1'b0;
        cyc_t(1);
        RST = 1'b0;
        base = pulses;
        cyc_t(20);
        check("t5_rst_nostep", 32'(pulses - base), 32'd0);
        check("t5_rst_cnt",    32'(STEP_CNT),      32'd0);

`ifdef AUTO_STEP_EN
        base = pulses;
        np = 0;
        SW_AUTO = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc_t(1);
            if (STEP === 1'b1 && np < 5) begin
                ptimes[np] = cyc;
                np++;
            end
        end
        SW_AUTO = 1'b0;
        cyc_t(30);
        check("t6_pulses", 32'(pulses - base), 32'd5);
        check("t6_seen",   32'(np),            32'd5);
        for (int i = 1; i < np; i++) begin
            check("t6_gap", 32'(ptimes[i] - ptimes[i-1]), 32'd8);
        end
`else
        np = 0;
        ptimes[0] = 0;
        SW_AUTO = 1'b1;
        base = pulses;
        cyc_t(40);
        SW_AUTO = 1'b0;
        check("t6_noauto", 32'(pulses - base), 32'(np + ptimes[0]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
